// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the arbiter FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_CMP = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req after position last, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] gid,
    output logic           any
);

    logic [IDW:0] idx;

    always_comb begin
        grant = '0;
        gid   = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            // One spare bit so last+i cannot overflow before the wrap.
            idx = {1'b0, last} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N)) begin
                idx = idx - (IDW+1)'(N);
            end
            if (!any && req[idx[IDW-1:0]]) begin
                any                   = 1'b1;
                grant[idx[IDW-1:0]]   = 1'b1;
                gid                   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one external combinational ALU between NREQ requesters.
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters on stat_cnt.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [W-1:0]      alu_res,
    input  logic              alu_car,
    input  logic              alu_of,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_res,
    output logic              rsp_car,
    output logic              rsp_of
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0] stat_cnt
`endif
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] last_q;
    logic [W-1:0]   a_q, b_q;
    logic [2:0]     op_q;
    logic [IDW-1:0] id_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_res_q;
    logic           rsp_car_q, rsp_of_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic            any;
    logic            req_hs, rsp_hs;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant),
        .gid   (gid),
        .any   (any)
    );

    assign req_hs    = (state_q == ARB_IDLE) && any;
    assign rsp_hs    = (state_q == ARB_RESP) && rsp_ready;
    assign req_ready = (state_q == ARB_IDLE) ? grant : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (any)       state_d = ARB_EXEC;
            ARB_EXEC:                state_d = ARB_RESP;
            ARB_RESP: if (rsp_ready) state_d = ARB_IDLE;
            default:                 state_d = ARB_IDLE;
        endcase
    end

    // Operand registers double as the ALU drive, so ALU inputs only change on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            last_q      <= IDW'(NREQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_car_q   <= 1'b0;
            rsp_of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                a_q  <= req_a[gid*W +: W];
                b_q  <= req_b[gid*W +: W];
                op_q <= req_op[gid*3 +: 3];
                id_q <= gid;
            end
            if (state_q == ARB_EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_res_q   <= alu_res;
                rsp_car_q   <= alu_car;
                rsp_of_q    <= alu_of;
            end
            if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
                last_q      <= rsp_id_q;
            end
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctrl  = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_car   = rsp_car_q;
    assign rsp_of    = rsp_of_q;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (req_hs && (cnt_q[gid] != 8'hFF)) begin
            cnt_q[gid] <= cnt_q[gid] + 8'd1;
        end
    end

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_stat
        assign stat_cnt[g*8 +: 8] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model plus directed literal checks.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic [11:0] req_op;
    logic [3:0]  alu_a, alu_b, alu_res;
    logic [2:0]  alu_ctrl;
    logic        alu_car, alu_of;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_res;
    logic        rsp_car, rsp_of;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(4), .W(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_res   (alu_res),
        .alu_car   (alu_car),
        .alu_of    (alu_of),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_car   (rsp_car),
        .rsp_of    (rsp_of)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    // External ALU stand-in; returns {of, car, res}.
    function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, o;
        s = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0]; c = s[4];
                o = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0]; c = s[4];
                o = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (a < b) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {o, c, r};
    endfunction

    assign {alu_of, alu_car, alu_res} = alu_ref(alu_a, alu_b, alu_ctrl);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected DUT event", name);
    endtask

    // Transaction-level model: at most one op in flight; response one cycle after the EXEC cycle.
    bit         m_pend = 1'b0;
    int         m_age  = 0;
    int         m_id   = 0;
    int         m_last = 3;
    logic [3:0] m_a = '0, m_b = '0, m_la = '0, m_lb = '0;
    logic [2:0] m_op = '0, m_lop = '0;
    int         m_cnt [4] = '{0, 0, 0, 0};

    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        int         p;
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                p = pick(req_valid, m_last);
                check("req_ready", req_ready, (!m_pend && p >= 0) ? (32'd1 << p) : 32'd0);
                check("alu_a", alu_a, m_la);
                check("alu_b", alu_b, m_lb);
                check("alu_ctrl", alu_ctrl, m_lop);
                check("rsp_valid", rsp_valid, m_pend && m_age >= 1);
                if (m_pend && m_age >= 1) begin
                    e = alu_ref(m_a, m_b, m_op);
                    check("rsp_id", rsp_id, m_id);
                    check("rsp_res", rsp_res, e[3:0]);
                    check("rsp_car", rsp_car, e[4]);
                    check("rsp_of", rsp_of, e[5]);
                end
`ifdef ALU_ARB_STATS_EN
                for (int i = 0; i < 4; i++) begin
                    check("stat_cnt", stat_cnt[i*8 +: 8], m_cnt[i]);
                end
`endif
            end
            @(posedge clk);
            if (!rst_n) begin
                m_pend = 1'b0; m_last = 3;
                m_la = '0; m_lb = '0; m_lop = '0;
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (!m_pend) begin
                p = pick(req_valid, m_last);
                if (p >= 0) begin
                    m_pend = 1'b1; m_age = 0; m_id = p;
                    m_a = req_a[p*4 +: 4]; m_b = req_b[p*4 +: 4]; m_op = req_op[p*3 +: 3];
                    m_la = m_a; m_lb = m_b; m_lop = m_op;
                    if (m_cnt[p] < 255) m_cnt[p]++;
                end
            end else if (m_age >= 1 && rsp_ready) begin
                m_pend = 1'b0;
                m_last = m_id;
            end else begin
                m_age++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op);
        req_valid[i]     = 1'b1;
        req_a[i*4 +: 4]  = a;
        req_b[i*4 +: 4]  = b;
        req_op[i*3 +: 3] = op;
    endtask

    // Returns just after the handshake edge, i.e. inside the EXEC cycle.
    task automatic do_op(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
        bit done;
        done = 1'b0;
        set_req(i, a, b, op);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (req_ready[i]) done = 1'b1;
            step();
        end
        req_valid[i] = 1'b0;
        if (!done) timeout("do_op");
    endtask

    // Returns at the negedge of the first cycle with rsp_valid high.
    task automatic wait_rsp();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        if (!found) timeout("wait_rsp");
    endtask

    initial begin
        logic [3:0] sv_res;
        logic [1:0] sv_id;
        int         ord[$];
        int         exp_ord[5] = '{0, 1, 2, 3, 0};
        int         n;

        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Test 1: first op after reset, requester 0.
        set_req(0, 4'd3, 4'd4, 3'b000);
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0001);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_exec_valid", rsp_valid, 1'b0);
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_id", rsp_id, 2'd0);
        check("t1_res", rsp_res, 4'd7);
        check("t1_car", rsp_car, 1'b0);
        check("t1_of", rsp_of, 1'b0);
        step();

        // Test 3: add overflow and subtract.
        do_op(1, 4'd7, 4'd1, 3'b000);
        wait_rsp();
        check("t3_add_id", rsp_id, 2'd1);
        check("t3_add_res", rsp_res, 4'd8);
        check("t3_add_of", rsp_of, 1'b1);
        check("t3_add_car", rsp_car, 1'b0);
        step();
        do_op(2, 4'd2, 4'd3, 3'b001);
        wait_rsp();
        check("t3_sub_id", rsp_id, 2'd2);
        check("t3_sub_res", rsp_res, 4'hF);
        check("t3_sub_car", rsp_car, 1'b0);
        check("t3_sub_of", rsp_of, 1'b0);
        step();

        // Test 4: response back-pressure with another requester waiting.
        rsp_ready = 1'b0;
        do_op(2, 4'd5, 4'd6, 3'b101);
        set_req(3, 4'd1, 4'd1, 3'b000);
        wait_rsp();
        sv_res = rsp_res;
        sv_id  = rsp_id;
        check("t4_res", sv_res, 4'd3);
        check("t4_id", sv_id, 2'd2);
        for (int k = 0; k < 5; k++) begin
            check("t4_ready_zero", req_ready, 4'b0000);
            check("t4_valid_held", rsp_valid, 1'b1);
            check("t4_res_stable", rsp_res, sv_res);
            check("t4_id_stable", rsp_id, sv_id);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_release", rsp_valid, 1'b1);
        step();
        @(negedge clk);
        check("t4_next_grant", req_ready, 4'b1000);
        step();
        req_valid[3] = 1'b0;
        wait_rsp();
        step();

        // Test 5: reset during EXEC aborts the op.
        do_op(1, 4'd9, 4'd6, 3'b000);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", rsp_valid, 1'b0);
        check("t5_rsp_res", rsp_res, 4'd0);
        check("t5_rsp_id", rsp_id, 2'd0);
        check("t5_alu_a", alu_a, 4'd0);
        check("t5_alu_b", alu_b, 4'd0);
        check("t5_alu_ctrl", alu_ctrl, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Test 2: all requesters valid, rotation from requester 0.
        req_valid = 4'b1111;
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 12'($urandom);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) check("t5_prio0", req_ready, 4'b0001);
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) ord.push_back(i);
            end
            step();
            req_a = 16'($urandom); req_b = 16'($urandom); req_op = 12'($urandom);
        end
        if (ord.size() < 5) begin
            timeout("t2_order");
        end else begin
            for (int i = 0; i < 5; i++) check("t2_order", ord[i], exp_ord[i]);
        end

        // Random traffic with random back-pressure; the model checks every cycle.
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            req_a = 16'($urandom); req_b = 16'($urandom); req_op = 12'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();

`ifdef ALU_ARB_STATS_EN
        // Test 6: counter saturation on requester 3.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        set_req(3, 4'd2, 4'd2, 3'b011);
        n = 0;
        for (int c = 0; c < 2000 && n < 300; c++) begin
            @(negedge clk);
            if (req_ready[3]) n++;
            step();
        end
        req_valid = '0;
        if (n < 300) timeout("t6_grants");
        repeat (4) step();
        check("t6_cnt3", stat_cnt[31:24], 8'd255);
        check("t6_cnt0", stat_cnt[7:0], 8'd0);
        check("t6_cnt1", stat_cnt[15:8], 8'd0);
        check("t6_cnt2", stat_cnt[23:16], 8'd0);
`else
        n = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
